// File: rtl/aes_spi_sequencer.sv
// ============================================================================
// Module   : aes_spi_sequencer
// Brief    : Serialises one AES block request (text, key size, key) over a
//            byte-wide SPI master and collects the 16-byte result.
//            Optional feature macro: SEQ_TIMEOUT_EN (per-byte m_done timeout).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module aes_spi_sequencer #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         req,
    output logic         ready,
    input  logic [127:0] text_in,
    input  logic [255:0] key_in,
    input  logic [7:0]   key_size,
    output logic [127:0] text_out,
    output logic         res_valid,
    output logic         err,
    output logic         m_start,
    input  logic         m_buzy,
    input  logic         m_done,
    output logic [7:0]   m_data_in,
    input  logic [7:0]   m_data_out
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SEND_TXT = 3'd1,
        SEND_KSZ = 3'd2,
        SEND_KEY = 3'd3,
        RECV     = 3'd4,
        FINISH   = 3'd5
    } state_t;

    if (TIMEOUT_CYCLES < 2) begin : g_param_check
        $error("TIMEOUT_CYCLES must be at least 2");
    end

    state_t         r_state, w_state_nxt;
    logic [5:0]     r_cnt, w_cnt_nxt;
    logic [127:0]   r_text, w_text_nxt;
    logic [255:0]   r_key, w_key_nxt;
    logic [7:0]     r_ksz, w_ksz_nxt;
    logic           r_inflight, w_inflight_nxt;
    logic [127:0]   r_text_out, w_text_out_nxt;
    logic           r_err, w_err_nxt;
    logic           w_ks_ok;
    logic           w_byte_done;
    logic           w_xfer_state;

`ifdef SEQ_TIMEOUT_EN
    localparam int c_TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_TMO_W-1:0] c_TMO_LAST = c_TMO_W'(TIMEOUT_CYCLES - 1);
    logic [c_TMO_W-1:0] r_tmo, w_tmo_nxt;
`endif

    assign w_ks_ok      = (key_size == 8'd16) || (key_size == 8'd24) || (key_size == 8'd32);
    assign w_byte_done  = r_inflight && m_done;
    assign w_xfer_state = (r_state == SEND_TXT) || (r_state == SEND_KSZ) ||
                          (r_state == SEND_KEY) || (r_state == RECV);

    assign ready     = (r_state == IDLE);
    assign res_valid = (r_state == FINISH);
    assign err       = r_err;
    assign text_out  = r_text_out;

    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_text_nxt     = r_text;
        w_key_nxt      = r_key;
        w_ksz_nxt      = r_ksz;
        w_inflight_nxt = r_inflight;
        w_text_out_nxt = r_text_out;
        w_err_nxt      = 1'b0;
        m_start        = 1'b0;
        m_data_in      = 8'h00;
`ifdef SEQ_TIMEOUT_EN
        w_tmo_nxt      = r_tmo;
`endif

        // Text and key are shifted out MSB first; r_text then collects the reply.
        case (r_state)
            IDLE: begin
                if (req) begin
                    w_text_nxt = text_in;
                    w_key_nxt  = key_in;
                    w_ksz_nxt  = key_size;
                    if (w_ks_ok) begin
                        w_state_nxt = SEND_TXT;
                        w_cnt_nxt   = 6'd15;
                    end else begin
                        w_err_nxt = 1'b1;
                    end
                end
            end
            SEND_TXT: begin
                m_data_in = r_text[127:120];
                if (w_byte_done) begin
                    w_text_nxt = {r_text[119:0], 8'h00};
                    if (r_cnt == 6'd0) begin
                        w_state_nxt = SEND_KSZ;
                        w_cnt_nxt   = 6'd0;
                    end else begin
                        w_cnt_nxt = r_cnt - 6'd1;
                    end
                end
            end
            SEND_KSZ: begin
                m_data_in = r_ksz;
                if (w_byte_done) begin
                    w_state_nxt = SEND_KEY;
                    w_cnt_nxt   = 6'(r_ksz - 8'd1);
                end
            end
            SEND_KEY: begin
                m_data_in = r_key[255:248];
                if (w_byte_done) begin
                    w_key_nxt = {r_key[247:0], 8'h00};
                    if (r_cnt == 6'd0) begin
                        w_state_nxt = RECV;
                        w_cnt_nxt   = 6'd15;
                    end else begin
                        w_cnt_nxt = r_cnt - 6'd1;
                    end
                end
            end
            RECV: begin
                if (w_byte_done) begin
                    w_text_nxt = {r_text[119:0], m_data_out};
                    if (r_cnt == 6'd0) begin
                        w_state_nxt    = FINISH;
                        w_text_out_nxt = {r_text[119:0], m_data_out};
                    end else begin
                        w_cnt_nxt = r_cnt - 6'd1;
                    end
                end
            end
            FINISH: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        if (w_xfer_state && !r_inflight && !m_buzy) begin
            m_start        = 1'b1;
            w_inflight_nxt = 1'b1;
        end
        if (w_byte_done) begin
            w_inflight_nxt = 1'b0;
        end

`ifdef SEQ_TIMEOUT_EN
        // r_tmo holds the number of cycles elapsed since the byte's m_start.
        if (m_start) begin
            w_tmo_nxt = {{(c_TMO_W-1){1'b0}}, 1'b1};
        end else if (r_inflight && !m_done) begin
            if (r_tmo == c_TMO_LAST) begin
                w_err_nxt      = 1'b1;
                w_state_nxt    = IDLE;
                w_inflight_nxt = 1'b0;
                w_cnt_nxt      = 6'd0;
                w_text_out_nxt = r_text_out;
            end else begin
                w_tmo_nxt = r_tmo + 1'b1;
            end
        end
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_cnt      <= 6'd0;
            r_text     <= 128'd0;
            r_key      <= 256'd0;
            r_ksz      <= 8'd0;
            r_inflight <= 1'b0;
            r_text_out <= 128'd0;
            r_err      <= 1'b0;
`ifdef SEQ_TIMEOUT_EN
            r_tmo      <= '0;
`endif
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_text     <= w_text_nxt;
            r_key      <= w_key_nxt;
            r_ksz      <= w_ksz_nxt;
            r_inflight <= w_inflight_nxt;
            r_text_out <= w_text_out_nxt;
            r_err      <= w_err_nxt;
`ifdef SEQ_TIMEOUT_EN
            r_tmo      <= w_tmo_nxt;
`endif
        end
    end

endmodule

`default_nettype wire
